// File: rtl/level_meter.sv
// level_meter: peak/hold/decay, clip indicator and windowed max / zero-crossing metering.
// Define LEVEL_METER_ENERGY_EN to add the per-window sum-of-squares on energyOut.
module level_meter #(
    parameter int unsigned WINDOW_SAMPLES = 4800,
    parameter int unsigned SETTLE_SAMPLES = 48,
    parameter int unsigned HOLD_SAMPLES   = 480,
    parameter int unsigned DECAY_SHIFT    = 6,
    parameter int unsigned CLIP_LEVEL     = 32767,
    parameter int unsigned CLIP_HOLD      = 4800
) (
    input  logic               clk_48,
    input  logic               reset,
    input  logic               clear,
    input  logic signed [15:0] sampleIn,
    output logic [14:0]        peakOut,
    output logic               clipOut,
    output logic [14:0]        windowMax,
    output logic [15:0]        zcCount,
    output logic               windowDone,
    output logic [31:0]        energyOut
);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT
    } state_t;

    localparam logic [15:0] WIN_LAST    = 16'(WINDOW_SAMPLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);
    localparam logic [15:0] HOLD_INIT   = 16'(HOLD_SAMPLES);
    localparam logic [15:0] CLIP_INIT   = 16'(CLIP_HOLD);
    localparam logic [14:0] CLIP_LVL    = 15'(CLIP_LEVEL);

    logic [15:0] neg_in;
    logic [14:0] mag_in;

    logic signed [15:0] s1_sample_q;
    logic [14:0]        s1_mag_q;
    logic               prev_neg_q;

    state_t      state_q, state_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [14:0] peak_q, peak_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] clip_cnt_q, clip_cnt_d;
    logic [14:0] win_max_q, win_max_d;
    logic [15:0] zc_acc_q, zc_acc_d;
    logic [14:0] wmax_out_q, wmax_out_d;
    logic [15:0] zc_out_q, zc_out_d;
    logic        done_q, done_d;

    logic        crossing;
    logic [14:0] decay;
    logic [15:0] zc_inc;

`ifdef LEVEL_METER_ENERGY_EN
    logic signed [31:0] sq;
    logic [47:0]        acc_q, acc_d;
    logic [31:0]        energy_q, energy_d;
`endif

    // -32768 has no positive 16-bit counterpart; it saturates to full scale.
    always_comb begin
        neg_in = ~sampleIn + 16'd1;
        if (!sampleIn[15])
            mag_in = sampleIn[14:0];
        else if (neg_in[15])
            mag_in = '1;
        else
            mag_in = neg_in[14:0];
    end

    always_comb begin
        crossing = prev_neg_q & ~s1_sample_q[15];
        decay    = peak_q >> DECAY_SHIFT;
        if (decay == '0)
            decay = 15'd1;
        zc_inc = (zc_acc_q == '1) ? zc_acc_q : zc_acc_q + {15'd0, crossing};

        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        peak_d       = peak_q;
        hold_d       = hold_q;
        clip_cnt_d   = clip_cnt_q;
        win_max_d    = win_max_q;
        zc_acc_d     = zc_acc_q;
        wmax_out_d   = wmax_out_q;
        zc_out_d     = zc_out_q;
        done_d       = 1'b0;
`ifdef LEVEL_METER_ENERGY_EN
        sq       = s1_sample_q * s1_sample_q;
        acc_d    = acc_q;
        energy_d = energy_q;
`endif

        if (s1_mag_q > peak_q) begin
            peak_d = s1_mag_q;
            hold_d = HOLD_INIT;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 16'd1;
        end else if (peak_q != '0) begin
            peak_d = peak_q - decay;
        end

        if (s1_mag_q >= CLIP_LVL)
            clip_cnt_d = CLIP_INIT;
        else if (clip_cnt_q != '0)
            clip_cnt_d = clip_cnt_q - 16'd1;

        case (state_q)
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_MEASURE;
                    settle_cnt_d = '0;
                    win_cnt_d    = '0;
                    win_max_d    = '0;
                    zc_acc_d     = '0;
`ifdef LEVEL_METER_ENERGY_EN
                    acc_d = '0;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            ST_MEASURE: begin
                win_cnt_d = win_cnt_q + 16'd1;
                win_max_d = (s1_mag_q > win_max_q) ? s1_mag_q : win_max_q;
                zc_acc_d  = zc_inc;
`ifdef LEVEL_METER_ENERGY_EN
                acc_d = acc_q + {16'd0, sq};
`endif
                if (win_cnt_q == WIN_LAST)
                    state_d = ST_REPORT;
            end
            ST_REPORT: begin
                // Publish the finished window; this edge's sample opens the next one.
                wmax_out_d = win_max_q;
                zc_out_d   = zc_acc_q;
                done_d     = 1'b1;
                win_max_d  = s1_mag_q;
                zc_acc_d   = {15'd0, crossing};
                win_cnt_d  = 16'd1;
                state_d    = ST_MEASURE;
`ifdef LEVEL_METER_ENERGY_EN
                energy_d = acc_q[47:16];
                acc_d    = {16'd0, sq};
`endif
            end
            default: state_d = ST_SETTLE;
        endcase

        if (clear) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            peak_d       = '0;
            hold_d       = '0;
            clip_cnt_d   = '0;
            win_max_d    = '0;
            zc_acc_d     = '0;
            wmax_out_d   = wmax_out_q;
            zc_out_d     = zc_out_q;
            done_d       = 1'b0;
`ifdef LEVEL_METER_ENERGY_EN
            acc_d    = '0;
            energy_d = energy_q;
`endif
        end
    end

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            s1_sample_q  <= '0;
            s1_mag_q     <= '0;
            prev_neg_q   <= 1'b0;
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            peak_q       <= '0;
            hold_q       <= '0;
            clip_cnt_q   <= '0;
            win_max_q    <= '0;
            zc_acc_q     <= '0;
            wmax_out_q   <= '0;
            zc_out_q     <= '0;
            done_q       <= 1'b0;
        end else begin
            s1_sample_q  <= sampleIn;
            s1_mag_q     <= mag_in;
            prev_neg_q   <= s1_sample_q[15];
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            peak_q       <= peak_d;
            hold_q       <= hold_d;
            clip_cnt_q   <= clip_cnt_d;
            win_max_q    <= win_max_d;
            zc_acc_q     <= zc_acc_d;
            wmax_out_q   <= wmax_out_d;
            zc_out_q     <= zc_out_d;
            done_q       <= done_d;
        end
    end

`ifdef LEVEL_METER_ENERGY_EN
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            energy_q <= '0;
        end else begin
            acc_q    <= acc_d;
            energy_q <= energy_d;
        end
    end

    assign energyOut = energy_q;
`else
    assign energyOut = '0;
`endif

    assign peakOut    = peak_q;
    assign clipOut    = (clip_cnt_q != '0);
    assign windowMax  = wmax_out_q;
    assign zcCount    = zc_out_q;
    assign windowDone = done_q;

endmodule
